fifo_read_packer: RTL and testbench

//  Downstream consumer of Async_Fifo read port, clk_read domain only. Drains bytes from FIFO,

---
 rtl/fifo_read_packer.sv | 143 ++++++++++++++
 tb/tb_fifo_read_packer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_packer.sv
// Packs consecutive FIFO read-port entries little-endian into wide words on a valid/ready stream.
// A flush closes the pending partial word with a byte-keep mask and a last marker.
module fifo_read_packer #(
  parameter int DATA_WIDTH       = 8,
  parameter int WORD_BYTES       = 4,
  parameter int FIFO_DEPTH_WIDTH = 5
) (
  input  logic                                 clk_read,
  input  logic                                 rst,
  input  logic                                 fifo_empty,
  input  logic [FIFO_DEPTH_WIDTH-1:0]          fifo_data_count,
  output logic                                 fifo_read,
  input  logic [DATA_WIDTH-1:0]                fifo_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATA_WIDTH*WORD_BYTES-1:0]     m_data,
  output logic [WORD_BYTES-1:0]                m_keep,
  output logic                                 m_last,
  input  logic                                 flush,
  output logic                                 flush_done,
  output logic [$clog2(WORD_BYTES):0]          level,
  output logic [1:0]                           dbg_state
);

  localparam int LW = $clog2(WORD_BYTES) + 1;
  localparam int MW = DATA_WIDTH * WORD_BYTES;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [LW-1:0] LEVEL_FULL = LW'(WORD_BYTES);

  // Stream handshake: a word transfers on every rising edge where m_valid && m_ready.
  // m_valid, m_data, m_keep and m_last stay stable from load until that transfer.

  logic [1:0]            state_q, state_d;
  logic                  inflight_q;
  logic [LW-1:0]         level_q;
  logic [DATA_WIDTH-1:0] acc_q [WORD_BYTES];
  logic                  m_valid_q;
  logic [MW-1:0]         m_data_q;
  logic [WORD_BYTES-1:0] m_keep_q;
  logic                  m_last_q;
  logic                  flush_done_q, flush_done_d;

  logic [LW:0]           fill;
  logic                  out_free;
  logic                  load_full;
  logic                  load_part;
  logic                  load_word;
  logic [MW-1:0]         word_data;
  logic [WORD_BYTES-1:0] word_keep;
  logic                  unused_count;

  assign unused_count = ^fifo_data_count;

  // Lanes held plus the read still in flight must never exceed one word.
  assign fill      = {1'b0, level_q} + {{LW{1'b0}}, inflight_q};
  assign fifo_read = !rst && (state_q == ST_RUN) && !fifo_empty &&
                     (fill < (LW+1)'(WORD_BYTES));

  assign out_free  = !m_valid_q || m_ready;
  assign load_full = (state_q == ST_RUN) && (level_q == LEVEL_FULL) && out_free;
  assign load_part = (state_q == ST_EMIT) && out_free;
  assign load_word = load_full || load_part;

  always_comb begin
    word_data = '0;
    word_keep = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (LW'(i) < level_q) begin
        word_data[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i];
        word_keep[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if (!inflight_q) state_d = (level_q == '0) ? ST_DONE : ST_EMIT;
      ST_EMIT:  if (out_free) state_d = ST_DONE;
      ST_DONE: begin
        // Wait for the closing word (or any older word) to leave the output register.
        if (out_free) begin
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end
      end
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_read) begin
    if (rst) begin
      state_q      <= ST_RUN;
      inflight_q   <= 1'b0;
      level_q      <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_q     <= 1'b0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < WORD_BYTES; i++) acc_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= fifo_read;
      flush_done_q <= flush_done_d;

      if (load_word) begin
        level_q <= '0;
      end else if (inflight_q) begin
        level_q <= level_q + LW'(1);
      end

      for (int i = 0; i < WORD_BYTES; i++) begin
        if (inflight_q && (level_q == LW'(i))) acc_q[i] <= fifo_data;
      end

      if (load_word) begin
        m_valid_q <= 1'b1;
        m_data_q  <= word_data;
        m_keep_q  <= word_keep;
        m_last_q  <= load_part;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_keep     = m_keep_q;
  assign m_last     = m_last_q;
  assign flush_done = flush_done_q;
  assign level      = level_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: emulated FIFO source, stream-level word model, directed and random traffic.
module tb_fifo_read_packer;

  localparam int DW = 8;
  localparam int WB = 4;
  localparam int CW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          fifo_empty;
  logic [CW-1:0] fifo_data_count;
  logic          fifo_read;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic [3:0]    m_keep;
  logic          m_last;
  logic          flush;
  logic          flush_done;
  logic [2:0]    level;
  logic [1:0]    dbg_state;

  fifo_read_packer #(.DATA_WIDTH(DW), .WORD_BYTES(WB), .FIFO_DEPTH_WIDTH(CW)) dut (
    .clk_read(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data_count(fifo_data_count),
    .fifo_read(fifo_read), .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .flush(flush),
    .flush_done(flush_done), .level(level), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- FIFO source emulation ----------------
  logic [7:0] src_q[$];
  bit toggle_mode = 0;
  bit rand_empty  = 0;
  bit ready_rand  = 0;
  bit phase       = 0;
  bit will_accept = 0;

  always @(negedge clk) will_accept = fifo_read && !fifo_empty;

  always @(posedge clk) begin
    #1;
    if (will_accept && src_q.size() > 0) fifo_data = src_q.pop_front();
    else fifo_data = 8'($urandom);
    phase = !phase;
    fifo_empty = (src_q.size() == 0) || (toggle_mode && phase) ||
                 (rand_empty && ($urandom_range(0, 2) == 0));
    fifo_data_count = (src_q.size() > 31) ? 5'd31 : 5'(src_q.size());
  end

  always @(posedge clk) begin
    #1;
    if (ready_rand) m_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stream-level model ----------------
  // Bytes form a little-endian stream cut into WB-byte words; a flush closes the remainder.
  logic [36:0] exp_q[$];
  logic [7:0]  part_q[$];
  logic [31:0] got_q[$];
  int          exp_done = 0;

  task automatic mdl_emit(input bit last);
    logic [31:0] d;
    logic [3:0]  k;
    d = '0;
    k = '0;
    for (int i = 0; i < part_q.size(); i++) begin
      d[8*i +: 8] = part_q[i];
      k[i] = 1'b1;
    end
    exp_q.push_back({last, k, d});
    part_q.delete();
  endtask

  task automatic mdl_add(input logic [7:0] b);
    part_q.push_back(b);
    if (part_q.size() == WB) mdl_emit(1'b0);
  endtask

  task automatic mdl_flush();
    if (part_q.size() > 0) mdl_emit(1'b1);
    exp_done++;
  endtask

  // ---------------- scoreboard / compare ----------------
  int          cyc = 0;
  int          last_acc_cyc = 0;
  bit          last_seen = 0;
  bit          prev_hold = 0;
  logic [36:0] prev_word;
  logic [36:0] e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_hold = 0;
      last_seen = 0;
    end else begin
      if (prev_hold) chk("hold_stable", {m_valid, m_last, m_keep, m_data}, {1'b1, prev_word});
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {m_last, m_keep, m_data}, 37'h0);
          if ({m_last, m_keep, m_data} == 37'h0) chk("unexpected_word_valid", m_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("word", {m_last, m_keep, m_data}, e);
        end
        if (m_last) begin
          last_seen    = 1;
          last_acc_cyc = cyc;
        end
      end
      if (flush_done) begin
        chk("flush_done_expected", (exp_done > 0), 1'b1);
        if (exp_done > 0) exp_done--;
        if (last_seen) chk("done_after_last", cyc - last_acc_cyc, 1);
        last_seen = 0;
      end
      prev_hold = m_valid && !m_ready;
      prev_word = {m_last, m_keep, m_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n, input bit to_model);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      src_q.push_back(b);
      if (to_model) mdl_add(b);
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 3000 && src_q.size() != 0; i++) tick();
    chk("src_drained", src_q.size(), 0);
    repeat (15) tick();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string nm);
    bit found;
    found = 0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (flush_done) found = 1;
    end
    chk(nm, found, 1'b1);
    tick();
  endtask

  // ---------------- main sequence ----------------
  int base;
  int n;

  initial begin
    rst = 1'b1; fifo_empty = 1'b1; fifo_data = '0; fifo_data_count = '0;
    m_ready = 1'b1; flush = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_fifo_read", fifo_read, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_m_keep", m_keep, 4'h0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_level", level, 3'd0);
    tick();
    rst = 1'b0;
    tick();

    // two full words, ready held high
    base = got_q.size();
    push_bytes(8'h00, 8, 1);
    settle();
    chk("t1_count", got_q.size() - base, 2);
    chk("t1_w0", got_q[base], 32'h03020100);
    chk("t1_w1", got_q[base+1], 32'h07060504);

    // downstream stall with accumulator full
    m_ready = 1'b0;
    base = got_q.size();
    push_bytes(8'h10, 12, 1);
    repeat (40) tick();
    @(negedge clk);
    chk("t2_read_idle", fifo_read, 1'b0);
    chk("t2_level_full", level, 3'd4);
    chk("t2_valid_held", m_valid, 1'b1);
    chk("t2_data_held", m_data, 32'h13121110);
    tick();
    m_ready = 1'b1;
    settle();
    chk("t2_count", got_q.size() - base, 3);
    chk("t2_w0", got_q[base], 32'h13121110);
    chk("t2_w1", got_q[base+1], 32'h17161514);
    chk("t2_w2", got_q[base+2], 32'h1B1A1918);

    // flush of a one-lane remainder
    base = got_q.size();
    push_bytes(8'h20, 5, 1);
    settle();
    mdl_flush();
    pulse_flush();
    wait_done(10, "t3_flush_done");
    chk("t3_count", got_q.size() - base, 2);
    chk("t3_w0", got_q[base], 32'h23222120);
    chk("t3_w1", got_q[base+1], 32'h00000024);

    // flush with nothing held
    base = got_q.size();
    mdl_flush();
    pulse_flush();
    wait_done(3, "t4_flush_done");
    chk("t4_no_word", got_q.size() - base, 0);

    // empty flag toggling every cycle
    base = got_q.size();
    toggle_mode = 1;
    push_bytes(8'h30, 6, 1);
    settle();
    toggle_mode = 0;
    mdl_flush();
    pulse_flush();
    wait_done(10, "t5_flush_done");
    chk("t5_w0", got_q[base], 32'h33323130);
    chk("t5_w1", got_q[base+1], 32'h00003534);

    // flush sampled on the edge that captures the fourth lane
    exp_q.push_back({1'b1, 4'hF, 32'h53525150});
    exp_done++;
    push_bytes(8'h50, 4, 0);
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
        @(negedge clk);
        if (level == 3'd3) found = 1;
      end
      chk("t7_level3_seen", found, 1'b1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    wait_done(12, "t7_flush_done");

    // reset mid-word
    push_bytes(8'hA0, 2, 1);
    repeat (8) tick();
    @(negedge clk);
    chk("t6_level_before", level, 3'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    part_q.delete();
    @(negedge clk);
    chk("t6_valid_after_rst", m_valid, 1'b0);
    chk("t6_level_after_rst", level, 3'd0);
    tick();
    base = got_q.size();
    push_bytes(8'h40, 4, 1);
    settle();
    chk("t6_count", got_q.size() - base, 1);
    chk("t6_w0", got_q[base], 32'h43424140);

    // randomized rounds
    for (int r = 0; r < 12; r++) begin
      rand_empty = 1;
      ready_rand = 1;
      n = $urandom_range(1, 11);
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        src_q.push_back(b);
        mdl_add(b);
      end
      for (int i = 0; i < 3000 && src_q.size() != 0; i++) tick();
      ready_rand = 0;
      rand_empty = 0;
      m_ready = 1'b1;
      settle();
      if ($urandom_range(0, 1) == 1) begin
        mdl_flush();
        pulse_flush();
        wait_done(12, "rand_flush_done");
      end
    end

    mdl_flush();
    pulse_flush();
    wait_done(12, "final_flush_done");
    repeat (10) tick();
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("exp_done_zero", exp_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
